// File: rtl/operand_fetch_unit.sv
// Operand fetch stage: latches a pair of source indices, reads the register file,
// applies writeback forwarding and holds the operand pair until the consumer takes it.
module operand_fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [31:0] op_data_1,
    output logic [31:0] op_data_2,
    input  logic        wb_valid,
    input  logic [4:0]  wb_idx,
    input  logic [31:0] wb_data,
    output logic [4:0]  rf_read_idx_1,
    output logic [4:0]  rf_read_idx_2,
    input  logic [31:0] rf_read_data_1,
    input  logic [31:0] rf_read_data_2,
    output logic [4:0]  rf_write_idx,
    output logic [31:0] rf_write_data,
    output logic        rf_write_enable,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q;
    logic        req_ready_q;
    logic        op_valid_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic        fwd1_vld_q;
    logic        fwd2_vld_q;
    logic [31:0] fwd1_data_q;
    logic [31:0] fwd2_data_q;
    logic [31:0] op1_q;
    logic [31:0] op2_q;
    logic [31:0] op1_d;
    logic [31:0] op2_d;
    logic        wb_live;
    logic        launch_hit1;
    logic        launch_hit2;
    logic        read_hit1;
    logic        read_hit2;

    // Handshakes: a request transfers on a cycle where req_valid && req_ready;
    // the operand pair transfers on a cycle where op_valid && op_ready.
    assign wb_live     = wb_valid && (wb_idx != 5'd0);
    assign launch_hit1 = wb_live && (wb_idx == req_rs1);
    assign launch_hit2 = wb_live && (wb_idx == req_rs2);
    assign read_hit1   = wb_live && (wb_idx == rs1_q);
    assign read_hit2   = wb_live && (wb_idx == rs2_q);

    // The RF read launched in the request cycle misses writes from that cycle and
    // from READ, so those are forwarded here; a READ-cycle write is the youngest.
    always_comb begin
        op1_d = rf_read_data_1;
        op2_d = rf_read_data_2;
        if (fwd1_vld_q) op1_d = fwd1_data_q;
        if (fwd2_vld_q) op2_d = fwd2_data_q;
        if (read_hit1)  op1_d = wb_data;
        if (read_hit2)  op2_d = wb_data;
        if (rs1_q == 5'd0) op1_d = 32'h0000_0000;
        if (rs2_q == 5'd0) op2_d = 32'h0000_0000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            op_valid_q  <= 1'b0;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            fwd1_vld_q  <= 1'b0;
            fwd2_vld_q  <= 1'b0;
            fwd1_data_q <= 32'h0000_0000;
            fwd2_data_q <= 32'h0000_0000;
            op1_q       <= 32'h0000_0000;
            op2_q       <= 32'h0000_0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        rs1_q       <= req_rs1;
                        rs2_q       <= req_rs2;
                        fwd1_vld_q  <= launch_hit1;
                        fwd2_vld_q  <= launch_hit2;
                        fwd1_data_q <= wb_data;
                        fwd2_data_q <= wb_data;
                        req_ready_q <= 1'b0;
                        state_q     <= READ;
                    end
                end
                READ: begin
                    op1_q      <= op1_d;
                    op2_q      <= op2_d;
                    op_valid_q <= 1'b1;
                    state_q    <= HOLD;
                end
                HOLD: begin
                    if (op_ready) begin
                        op_valid_q  <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    op_valid_q  <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign op_valid      = op_valid_q;
    assign op_data_1     = op1_q;
    assign op_data_2     = op2_q;
    assign rf_read_idx_1 = (state_q == IDLE) ? req_rs1 : rs1_q;
    assign rf_read_idx_2 = (state_q == IDLE) ? req_rs2 : rs2_q;

    // Writeback passes straight through and is deliberately independent of reset.
    assign rf_write_enable = wb_live;
    assign rf_write_idx    = wb_idx;
    assign rf_write_data   = wb_data;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Bench for operand_fetch_unit: a behavioural register file plus an architectural
// shadow of register contents that defines the expected operands.
module tb_operand_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_data_1;
    logic [31:0] op_data_2;
    logic        wb_valid;
    logic [4:0]  wb_idx;
    logic [31:0] wb_data;
    logic [4:0]  rf_read_idx_1;
    logic [4:0]  rf_read_idx_2;
    logic [31:0] rf_read_data_1;
    logic [31:0] rf_read_data_2;
    logic [4:0]  rf_write_idx;
    logic [31:0] rf_write_data;
    logic        rf_write_enable;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    logic        rf_load;
    logic [31:0] init_vals [32];
    logic [31:0] rf_mem [32];
    logic [31:0] shadow [32];

    operand_fetch_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_data_1(op_data_1), .op_data_2(op_data_2),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
        .rf_read_idx_1(rf_read_idx_1), .rf_read_idx_2(rf_read_idx_2),
        .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
        .rf_write_idx(rf_write_idx), .rf_write_data(rf_write_data),
        .rf_write_enable(rf_write_enable), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Register file: one-cycle read latency, read-before-write; x0 is not
    // hardwired so that the DUT alone must produce zero for index 0.
    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= init_vals[i];
        end else if (rf_write_enable) begin
            rf_mem[rf_write_idx] <= rf_write_data;
        end
        rf_read_data_1 <= rf_mem[rf_read_idx_1];
        rf_read_data_2 <= rf_mem[rf_read_idx_2];
    end

    // Architectural register contents from the bench's own writeback stimulus.
    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 32; i++) shadow[i] <= init_vals[i];
        end else if (wb_valid && wb_idx != 5'd0) begin
            shadow[wb_idx] <= wb_data;
        end
    end

    function automatic logic [31:0] arch_val(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'h0 : shadow[idx];
    endfunction

    // driver tasks (called at a negedge, return at a negedge)
    task automatic write_reg(input logic [4:0] idx, input logic [31:0] d);
        wb_valid = 1'b1; wb_idx = idx; wb_data = d;
        @(negedge clk);
        wb_valid = 1'b0;
    endtask

    task automatic drive_wb(input logic en, input logic [4:0] idx, input logic [31:0] d);
        wb_valid = en; wb_idx = idx; wb_data = d;
    endtask

    // One complete fetch; DUT must be idle on entry and is idle on return.
    task automatic fetch(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                         input int hold,
                         input logic lw_en, input logic [4:0] lw_idx, input logic [31:0] lw_d,
                         input logic rw_en, input logic [4:0] rw_idx, input logic [31:0] rw_d,
                         input logic hw_en, input logic [4:0] hw_idx, input logic [31:0] hw_d);
        logic [31:0] exp1, exp2;
        n_vec++;
        if (req_ready !== 1'b1 || op_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s launch_idle: req_ready=%b op_valid=%b expected 1/0", tag, req_ready, op_valid);
        end
        req_valid = 1'b1; req_rs1 = rs1; req_rs2 = rs2;
        drive_wb(lw_en, lw_idx, lw_d);
        @(negedge clk);
        req_valid = 1'b0;
        req_rs1 = 5'($urandom_range(0, 31));
        req_rs2 = 5'($urandom_range(0, 31));
        drive_wb(rw_en, rw_idx, rw_d);
        #1;
        n_vec++;
        if (req_ready !== 1'b0 || op_valid !== 1'b0 || rf_read_idx_1 !== rs1 || rf_read_idx_2 !== rs2) begin
            n_err++;
            $display("FAIL %s read_cycle: rdy=%b vld=%b idx=%0d/%0d expected 0/0 %0d/%0d",
                     tag, req_ready, op_valid, rf_read_idx_1, rf_read_idx_2, rs1, rs2);
        end
        @(negedge clk);
        exp1 = arch_val(rs1);
        exp2 = arch_val(rs2);
        for (int c = 0; c <= hold; c++) begin
            n_vec++;
            if (op_valid !== 1'b1 || req_ready !== 1'b0 || op_data_1 !== exp1 || op_data_2 !== exp2) begin
                n_err++;
                $display("FAIL %s hold%0d: vld=%b rdy=%b d1=%h d2=%h expected 1/0 %h %h",
                         tag, c, op_valid, req_ready, op_data_1, op_data_2, exp1, exp2);
            end
            if (c == 0) drive_wb(hw_en, hw_idx, hw_d);
            else drive_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
            op_ready = (c == hold);
            @(negedge clk);
        end
        op_ready = 1'b0;
        drive_wb(1'b0, 5'd0, 32'h0);
        n_vec++;
        if (op_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s release: op_valid=%b req_ready=%b expected 0/1", tag, op_valid, req_ready);
        end
    endtask

    task automatic fetch_plain(input string tag, input logic [4:0] rs1, input logic [4:0] rs2, input int hold);
        fetch(tag, rs1, rs2, hold, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_reset();
        reset = 1'b1; rf_load = 1'b1;
        req_valid = 1'b0; req_rs1 = 5'd0; req_rs2 = 5'd0; op_ready = 1'b0;
        wb_valid = 1'b0; wb_idx = 5'd0; wb_data = 32'h0;
        repeat (2) @(negedge clk);
        rf_load = 1'b0;
        n_vec++;
        if (op_valid !== 1'b0 || req_ready !== 1'b1 || op_data_1 !== 32'h0 || op_data_2 !== 32'h0) begin
            n_err++;
            $display("FAIL reset_state: vld=%b rdy=%b d1=%h d2=%h expected 0/1 0 0",
                     op_valid, req_ready, op_data_1, op_data_2);
        end
        wb_valid = 1'b1; wb_idx = 5'd3; wb_data = 32'h3333_0003;
        #1;
        n_vec++;
        if (rf_write_enable !== 1'b1) begin
            n_err++;
            $display("FAIL reset_wb_enable: got %b expected 1", rf_write_enable);
        end
        @(negedge clk);
        wb_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_writeback();
        logic [4:0]  idx;
        logic [31:0] d;
        wb_valid = 1'b1; wb_idx = 5'd0; wb_data = 32'hFFFF_FFFF;
        #1;
        n_vec++;
        if (rf_write_enable !== 1'b0) begin
            n_err++;
            $display("FAIL wb_x0: enable=%b expected 0", rf_write_enable);
        end
        for (int i = 0; i < 6; i++) begin
            idx = (i == 0) ? 5'd3 : 5'($urandom_range(0, 31));
            d = $urandom;
            wb_valid = 1'($urandom_range(0, 1)) | (i == 0);
            wb_idx = idx; wb_data = d;
            #1;
            n_vec++;
            if (rf_write_enable !== (wb_valid && idx != 5'd0) || rf_write_idx !== idx || rf_write_data !== d) begin
                n_err++;
                $display("FAIL wb_path: en=%b idx=%0d data=%h expected %b %0d %h",
                         rf_write_enable, rf_write_idx, rf_write_data, (wb_valid && idx != 5'd0), idx, d);
            end
            @(negedge clk);
        end
        wb_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle_follow();
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b0;
            req_rs1 = 5'($urandom_range(0, 31));
            req_rs2 = 5'($urandom_range(0, 31));
            #1;
            n_vec++;
            if (rf_read_idx_1 !== req_rs1 || rf_read_idx_2 !== req_rs2) begin
                n_err++;
                $display("FAIL idle_follow: idx=%0d/%0d expected %0d/%0d", rf_read_idx_1, rf_read_idx_2, req_rs1, req_rs2);
            end
            @(negedge clk);
            n_vec++;
            if (req_ready !== 1'b1 || op_valid !== 1'b0) begin
                n_err++;
                $display("FAIL idle_stay: rdy=%b vld=%b expected 1/0", req_ready, op_valid);
            end
        end
    endtask

    task automatic test_basic_fetch();
        write_reg(5'd5, 32'h11);
        write_reg(5'd6, 32'h22);
        fetch_plain("basic", 5'd5, 5'd6, 0);
        n_vec++;
        if (shadow[5] !== 32'h11 || shadow[6] !== 32'h22) begin
            n_err++;
            $display("FAIL basic_model: x5=%h x6=%h expected 11 22", shadow[5], shadow[6]);
        end
    endtask

    task automatic test_x0_self_pair();
        fetch_plain("x0_pair", 5'd0, 5'd0, 0);
        fetch_plain("self_pair", 5'd7, 5'd7, 1);
        fetch("self_pair_fwd", 5'd7, 5'd7, 0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h7777_7777, 1'b0, 5'd0, 32'h0);
        fetch("x0_write", 5'd0, 5'd9, 0, 1'b1, 5'd0, 32'hBAD0_0000, 1'b1, 5'd0, 32'hBAD0_0001, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_forwarding();
        write_reg(5'd5, 32'h55);
        fetch("fwd_launch", 5'd5, 5'd6, 0, 1'b1, 5'd5, 32'hAA, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        fetch("fwd_both", 5'd5, 5'd6, 0, 1'b1, 5'd5, 32'hBB, 1'b1, 5'd5, 32'hCC, 1'b0, 5'd0, 32'h0);
        fetch("fwd_hold", 5'd5, 5'd6, 2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDD);
        fetch("fwd_rs2", 5'd6, 5'd5, 0, 1'b1, 5'd5, 32'hE1, 1'b1, 5'd6, 32'hE2, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_backpressure();
        fetch_plain("backpressure", 5'd5, 5'd6, 5);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++)
            fetch_plain("back_to_back", 5'($urandom_range(1, 31)), 5'($urandom_range(0, 31)), 0);
    endtask

    task automatic test_reset_mid_op();
        req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd6;
        @(negedge clk);
        req_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_vec++;
        if (op_valid !== 1'b0 || req_ready !== 1'b1 || op_data_1 !== 32'h0 || op_data_2 !== 32'h0) begin
            n_err++;
            $display("FAIL reset_in_read: vld=%b rdy=%b d1=%h d2=%h expected 0/1 0 0",
                     op_valid, req_ready, op_data_1, op_data_2);
        end
        @(negedge clk);
        n_vec++;
        if (op_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_pulse: op_valid=%b expected 0", op_valid);
        end
        req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd6;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_vec++;
        if (op_valid !== 1'b0 || req_ready !== 1'b1 || op_data_1 !== 32'h0 || op_data_2 !== 32'h0) begin
            n_err++;
            $display("FAIL reset_in_hold: vld=%b rdy=%b d1=%h d2=%h expected 0/1 0 0",
                     op_valid, req_ready, op_data_1, op_data_2);
        end
        fetch_plain("after_reset", 5'd5, 5'd6, 0);
    endtask

    task automatic test_random();
        logic [4:0] rs1, rs2;
        logic [4:0] wi [3];
        for (int n = 0; n < 40; n++) begin
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            for (int k = 0; k < 3; k++) begin
                case ($urandom_range(0, 2))
                    0: wi[k] = rs1;
                    1: wi[k] = rs2;
                    default: wi[k] = 5'($urandom_range(0, 7));
                endcase
            end
            fetch("random", rs1, rs2, $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), wi[0], $urandom,
                  1'($urandom_range(0, 1)), wi[1], $urandom,
                  1'($urandom_range(0, 1)), wi[2], $urandom);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) init_vals[i] = $urandom;
        init_vals[0] = 32'hDEAD_BEEF;
        test_reset();
        test_writeback();
        test_idle_follow();
        test_basic_fetch();
        test_x0_self_pair();
        test_forwarding();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/operand_fetch_unit.md
OPERAND_FETCH_UNIT -- requirements
Module: operand_fetch_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have the port `clk`: input, 1 bit, rising-edge clock.
REQ-003 The block SHALL have the port `reset`: input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have the port `req_valid`: input, 1 bit, decode requests an operand fetch.
REQ-005 The block SHALL have the port `req_ready`: output, 1 bit, block accepts a fetch request.
REQ-006 The block SHALL have the ports `req_rs1` and `req_rs2`: input, 5 bits each, source register indices.
REQ-007 The block SHALL have the port `op_valid`: output, 1 bit, operand pair is valid.
REQ-008 The block SHALL have the port `op_ready`: input, 1 bit, consumer takes the operands.
REQ-009 The block SHALL have the ports `op_data_1` and `op_data_2`: output, 32 bits each, operand values.
REQ-010 The block SHALL have the port `wb_valid`: input, 1 bit, writeback request.
REQ-011 The block SHALL have the port `wb_idx`: input, 5 bits, destination register.
REQ-012 The block SHALL have the port `wb_data`: input, 32 bits, writeback value.
REQ-013 The block SHALL have the ports `rf_read_idx_1` and `rf_read_idx_2`: output, 5 bits each, register-file read indices.
REQ-014 The block SHALL have the ports `rf_read_data_1` and `rf_read_data_2`: input, 32 bits each; the register file returns the data one clock after the index is sampled.
REQ-015 The block SHALL have the port `rf_write_idx`: output, 5 bits, register-file write index.
REQ-016 The block SHALL have the port `rf_write_data`: output, 32 bits, register-file write data.
REQ-017 The block SHALL have the port `rf_write_enable`: output, 1 bit, register-file write strobe.

Function
REQ-018 FSM states SHALL be IDLE, READ and HOLD.
REQ-019 In IDLE:
- `req_ready` SHALL be 1 and `op_valid` SHALL be 0.
- `rf_read_idx_1` and `rf_read_idx_2` SHALL be driven combinationally from `req_rs1` and `req_rs2`.
- On `req_valid`=1, the block SHALL latch rs1/rs2 and move to READ.
REQ-020 In READ:
- `req_ready` SHALL be 0 and `op_valid` SHALL be 0.
- `rf_read_idx_*` SHALL hold the latched indices.
- At the end of the cycle, the block SHALL capture the operands into the `op_data_*` registers and move to HOLD.
REQ-021 In HOLD:
- `op_valid` SHALL be 1 and `op_data_*` SHALL be stable.
- On `op_ready`=1, the block SHALL return to IDLE.
- A new request SHALL NOT be accepted in the same cycle; the minimum request-to-request spacing is 3 cycles.
REQ-022 Operand capture rule: an index equal to 0 SHALL yield 0x00000000 regardless of the `rf_read_data_*` value.
REQ-023 Forwarding: a write accepted in the launch cycle (IDLE with the request accepted) or in the READ cycle whose `wb_idx` matches a latched nonzero index SHALL supply that operand. When both cycles match, the READ-cycle value SHALL win. Otherwise the `rf_read_data_*` value SHALL be used.
REQ-024 Writes accepted while in HOLD SHALL NOT alter `op_data_*`.
REQ-025 The writeback path SHALL be combinational:
- `rf_write_enable` = `wb_valid` AND (`wb_idx` != 0).
- `rf_write_idx` = `wb_idx`.
- `rf_write_data` = `wb_data`.
Writeback SHALL be accepted in every state, including during reset.
REQ-026 When rs1 equals rs2, both operands SHALL receive identical values, including the forwarded value.
REQ-027 When `req_valid` is deasserted in IDLE, the FSM SHALL remain in IDLE and `rf_read_idx_*` SHALL follow the `req_rs*` inputs (don't-care).

Reset
REQ-028 While `reset` is 1, at the next rising edge the state SHALL become IDLE, `op_data_1` and `op_data_2` SHALL become 0x00000000, `op_valid` SHALL become 0 and `req_ready` SHALL become 1.
REQ-029 Reset asserted in READ or HOLD SHALL abort the fetch with no output pulse; the operand pair SHALL be discarded.
REQ-030 Reset SHALL NOT gate `rf_write_enable`.

Verification
REQ-031 Basic fetch: RF x5=0x11, x6=0x22; request rs1=5, rs2=6 -> `op_valid` at cycle +2, `op_data_1`=0x11, `op_data_2`=0x22.
REQ-032 x0 and self-pair: rs1=0, rs2=0, with the RF returning 0xDEADBEEF -> both operands are 0x00000000. A separate request with rs1=rs2=7 -> identical operands.
REQ-033 Forwarding: a write of x5=0xAA in the launch cycle -> `op_data_1`=0xAA. A write of x5=0xBB in the launch cycle and x5=0xCC in READ -> `op_data_1`=0xCC. A write of x5=0xDD in HOLD -> `op_data_1` unchanged.
REQ-034 Backpressure: `op_ready` held low for 5 cycles in HOLD -> `op_valid` stays 1, data stable, `req_ready`=0. Then `op_ready`=1 -> IDLE next cycle.
REQ-035 Writeback: `wb_valid`=1 with `wb_idx`=0 -> `rf_write_enable`=0. `wb_valid`=1 with `wb_idx`=3 -> enable=1, idx=3.
REQ-036 Reset mid-operation: reset in READ -> next cycle `op_valid`=0, `req_ready`=1, `op_data_*`=0; a subsequent fetch completes normally.
